// File: rtl/bcd_countdown_timer_if.sv
// Signal bundle between the BCD countdown timer, its ms tick source and the game controller.
// The master side drives ticks and commands; the slave side is the countdown timer itself.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 2
);
  logic                  ms_tick;
  logic                  tick_enable;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   time_bcd;
  logic                  running;
  logic                  done;
  logic                  expired;

  modport master (
    output ms_tick, load, load_value, start, pause,
    input  tick_enable, time_bcd, running, done, expired
  );

  modport slave (
    input  ms_tick, load, load_value, start, pause,
    output tick_enable, time_bcd, running, done, expired
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Packed-BCD seconds countdown driven by millisecond ticks, with load/start/pause control
// and a one-cycle expiry pulse that follows entry into DONE by one clock.
module bcd_countdown_timer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int DIGITS        = 2
) (
  input logic clk,
  input logic reset,
  bcd_countdown_timer_if.slave bus
);
  localparam int W     = 4 * DIGITS;
  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t           state_reg;
  logic [W-1:0]     time_reg;
  logic [SUB_W-1:0] sub_cnt_reg;
  logic             tick_enable_reg;
  logic             running_reg;
  logic             done_reg;
  logic             expired_reg;
  logic             expire_pending_reg;

  logic [W-1:0]      clamp_value;
  logic [W-1:0]      dec_value;
  logic [DIGITS-1:0] borrow;
  logic              start_eff;

  // pause beats start when both arrive together
  assign start_eff = bus.start && !bus.pause;
  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur_nib;
      logic [3:0] load_nib;
      assign cur_nib  = time_reg[4*gi +: 4];
      assign load_nib = bus.load_value[4*gi +: 4];
      assign clamp_value[4*gi +: 4] = (load_nib > 4'd9) ? 4'd9 : load_nib;
      assign dec_value[4*gi +: 4] = !borrow[gi] ? cur_nib :
                                    (cur_nib == 4'd0) ? 4'd9 : cur_nib - 4'd1;
      if (gi < DIGITS - 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] && (cur_nib == 4'd0);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      time_reg           <= '0;
      sub_cnt_reg        <= '0;
      tick_enable_reg    <= 1'b0;
      running_reg        <= 1'b0;
      done_reg           <= 1'b0;
      expired_reg        <= 1'b0;
      expire_pending_reg <= 1'b0;
    end else begin
      // expiry pulse trails DONE entry by one cycle unless a load cancels it
      expired_reg        <= expire_pending_reg && !bus.load;
      expire_pending_reg <= 1'b0;
      if (bus.load) begin
        state_reg       <= IDLE;
        time_reg        <= clamp_value;
        sub_cnt_reg     <= '0;
        tick_enable_reg <= 1'b0;
        running_reg     <= 1'b0;
        done_reg        <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_eff) begin
              if (time_reg != '0) begin
                state_reg       <= RUN;
                tick_enable_reg <= 1'b1;
                running_reg     <= 1'b1;
              end else begin
                state_reg          <= DONE;
                done_reg           <= 1'b1;
                expire_pending_reg <= 1'b1;
              end
            end
          end
          RUN: begin
            if (bus.pause) begin
              state_reg       <= PAUSED;
              tick_enable_reg <= 1'b0;
              running_reg     <= 1'b0;
            end else if (bus.ms_tick) begin
              if (sub_cnt_reg == SUB_MAX) begin
                sub_cnt_reg <= '0;
                time_reg    <= dec_value;
                if (dec_value == '0) begin
                  state_reg          <= DONE;
                  tick_enable_reg    <= 1'b0;
                  running_reg        <= 1'b0;
                  done_reg           <= 1'b1;
                  expire_pending_reg <= 1'b1;
                end
              end else begin
                sub_cnt_reg <= sub_cnt_reg + SUB_W'(1);
              end
            end
          end
          PAUSED: begin
            if (start_eff) begin
              state_reg       <= RUN;
              tick_enable_reg <= 1'b1;
              running_reg     <= 1'b1;
            end
          end
          DONE: begin
            time_reg <= '0;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.tick_enable = tick_enable_reg;
  assign bus.time_bcd    = time_reg;
  assign bus.running     = running_reg;
  assign bus.done        = done_reg;
  assign bus.expired     = expired_reg;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: an integer-seconds model predicts each cycle's
// outputs, plus fixed spot checks at the second boundaries of each scenario.
module tb_bcd_countdown_timer;
  localparam int TPS = 1000;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.DIGITS(2)) bus ();

  bcd_countdown_timer #(.TICKS_PER_SEC(TPS), .DIGITS(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] t;
    logic [3:0] f;   // {tick_enable, running, done, expired}
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  int m_state, m_secs, m_sub;
  bit m_exp, m_pend;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int s);
    logic [3:0] tens, ones;
    tens = 4'(s / 10);
    ones = 4'(s % 10);
    return {tens, ones};
  endfunction

  function automatic int clamp_secs(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  task automatic compare_next(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_time"}, 32'(bus.time_bcd), 32'(e.t));
      check_val({tag, "_flags"}, 32'({bus.tick_enable, bus.running, bus.done, bus.expired}), 32'(e.f));
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.t = to_bcd(m_secs);
    e.f = {m_state == S_RUN, m_state == S_RUN, m_state == S_DONE, m_exp};
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic ld, input logic [7:0] lv, input logic st,
                       input logic ps, input logic tk);
    bus.load = ld; bus.load_value = lv; bus.start = st; bus.pause = ps; bus.ms_tick = tk;
    m_exp  = m_pend && !ld;
    m_pend = 1'b0;
    if (ld) begin
      m_secs = clamp_secs(lv); m_sub = 0; m_state = S_IDLE;
    end else begin
      case (m_state)
        S_IDLE: if (st && !ps) begin
          if (m_secs != 0) m_state = S_RUN;
          else begin m_state = S_DONE; m_pend = 1'b1; end
        end
        S_RUN: if (ps) m_state = S_PAUSED;
          else if (tk) begin
            m_sub++;
            if (m_sub == TPS) begin
              m_sub = 0; m_secs--;
              if (m_secs == 0) begin m_state = S_DONE; m_pend = 1'b1; end
            end
          end
        S_PAUSED: if (st && !ps) m_state = S_RUN;
        default: ;
      endcase
    end
    push_expected();
    compare_next("cyc");
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.ms_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.load = 1'b0; bus.load_value = 8'h00; bus.start = 1'b0; bus.pause = 1'b0; bus.ms_tick = 1'b0;
    m_state = S_IDLE; m_secs = 0; m_sub = 0; m_exp = 1'b0; m_pend = 1'b0;
    push_expected();
    compare_next("reset");
    reset = 1'b0;
  endtask

  // each tick is a one-cycle pulse followed by an idle cycle
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    check_val("rst_flags", 32'({bus.tick_enable, bus.running, bus.done, bus.expired}), 32'h0);
    $display("reset: time=%h", bus.time_bcd);

    // 1: count 03 down to zero
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_val("t1_tick_en", 32'(bus.tick_enable), 32'd1);
    ticks(999);
    check_val("t1_t999", 32'(bus.time_bcd), 32'h03);
    ticks(1);
    check_val("t1_t1000", 32'(bus.time_bcd), 32'h02);
    ticks(1000);
    check_val("t1_t2000", 32'(bus.time_bcd), 32'h01);
    ticks(999);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("t1_done", 32'({bus.time_bcd, bus.done, bus.expired, bus.tick_enable}), 32'({8'h00, 3'b100}));
    idle(1);
    check_val("t1_expired", 32'(bus.expired), 32'd1);
    idle(1);
    check_val("t1_exp_pulse", 32'(bus.expired), 32'd0);
    ticks(3);
    check_val("t1_done_hold", 32'(bus.done), 32'd1);
    $display("test1: time=%h done=%b", bus.time_bcd, bus.done);

    // 2: 10 -> 09 borrow
    drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks(1000);
    check_val("t2_borrow", 32'(bus.time_bcd), 32'h09);
    check_val("t2_running", 32'(bus.running), 32'd1);
    $display("test2: time=%h running=%b", bus.time_bcd, bus.running);

    // 3: pause keeps sub-second progress; tick coinciding with pause is dropped
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks(500);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check_val("t3_paused_te", 32'(bus.tick_enable), 32'd0);
    ticks(50);
    check_val("t3_paused_time", 32'(bus.time_bcd), 32'h02);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    check_val("t3_pause_wins", 32'(bus.running), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks(499);
    check_val("t3_t999", 32'(bus.time_bcd), 32'h02);
    ticks(1);
    check_val("t3_t1000", 32'(bus.time_bcd), 32'h01);
    $display("test3: time=%h", bus.time_bcd);

    // 4: clamp, and zero-start goes straight to DONE; load cancels the pending pulse
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check_val("t4_clamp", 32'(bus.time_bcd), 32'h95);
    drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    check_val("t4_clamp_lo", 32'(bus.time_bcd), 32'h39);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_val("t4_zero_done", 32'(bus.done), 32'd1);
    idle(1);
    check_val("t4_zero_exp", 32'(bus.expired), 32'd1);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    check_val("t4_load_cancel", 32'({bus.expired, bus.done}), 32'd0);
    $display("test4: time=%h", bus.time_bcd);

    // 5: load mid-RUN aborts and clears sub-second progress
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks(1200);
    check_val("t5_mid", 32'(bus.time_bcd), 32'h04);
    drive(1'b1, 8'h07, 1'b0, 1'b0, 1'b1);
    check_val("t5_load", 32'({bus.time_bcd, bus.running, bus.expired}), 32'({8'h07, 2'b00}));
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks(999);
    check_val("t5_sub_cleared", 32'(bus.time_bcd), 32'h07);
    ticks(1);
    check_val("t5_next_sec", 32'(bus.time_bcd), 32'h06);
    $display("test5: time=%h", bus.time_bcd);

    // 6: reset mid-RUN
    drive(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks(100);
    do_reset();
    check_val("t6_reset", 32'({bus.time_bcd, bus.tick_enable, bus.running, bus.done, bus.expired}), 32'h0);
    ticks(5);
    check_val("t6_ignored", 32'({bus.time_bcd, bus.running}), 32'h0);
    $display("test6: time=%h running=%b", bus.time_bcd, bus.running);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
